// File: rtl/seq_alu_pkg.sv
// Shared op codes, FSM state encoding and flag bit positions for the sequential ALU.
package alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_MUL  = 4'b0010;
    localparam logic [3:0] ALU_AND  = 4'b0011;
    localparam logic [3:0] ALU_OR   = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_XOR  = 4'b1000;
    localparam logic [3:0] ALU_SLT  = 4'b1001;
    localparam logic [3:0] ALU_SLTU = 4'b1010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Flags are packed as {N,Z,C,V}
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/seq_alu_if.sv
// Operand/result bus of the sequential ALU. Flags exist only when ALU_FLAGS_EN is defined.
interface seq_alu_if #(
    parameter int WIDTH = 32
);
    // Handshake: a beat transfers on a rising clk edge where valid && ready are both 1.
    // The producer holds valid and its payload stable until that edge; ready may
    // depend combinationally on the downstream ready but never on valid.
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [3:0]       ALU_Op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Result;
`ifdef ALU_FLAGS_EN
    logic [3:0]       Flags;

    modport master (output in_valid, A, B, ALU_Op, out_ready,
                    input  in_ready, out_valid, Result, Flags);
    modport slave  (input  in_valid, A, B, ALU_Op, out_ready,
                    output in_ready, out_valid, Result, Flags);
`else
    modport master (output in_valid, A, B, ALU_Op, out_ready,
                    input  in_ready, out_valid, Result);
    modport slave  (input  in_valid, A, B, ALU_Op, out_ready,
                    output in_ready, out_valid, Result);
`endif

endinterface

// File: rtl/seq_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, WIDTH cycles, low half of product.
module seq_mul_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_product_lo
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;

    // No early-out: zero operands still run all WIDTH iterations.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else if (i_start) begin
            r_acc    <= '0;
            r_mcand  <= i_a;
            r_mplier <= i_b;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_done   <= 1'b0;
        end else if (r_busy) begin
            if (r_mplier[0]) begin
                r_acc <= r_acc + r_mcand;
            end
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
            if (r_cnt == LAST) begin
                r_busy <= 1'b0;
                r_done <= 1'b1;
            end
        end else begin
            r_done <= 1'b0;
        end
    end

    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_product_lo = r_acc;

endmodule

// File: rtl/seq_alu.sv
// Handshaked ALU with registered result and an iterative multiplier.
// Optional {N,Z,C,V} flags output enabled by defining ALU_FLAGS_EN.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic      clk,
    input  logic      rst,
    seq_alu_if.slave  bus,
    output state_t    o_state
);
    localparam int SHAMT_W = $clog2(WIDTH);

    state_t           r_state;
    logic [WIDTH-1:0] r_result;
    logic             r_out_valid;

    logic             w_accept;
    logic             w_start_mul;
    logic             w_mul_busy;
    logic             w_mul_done;
    logic [WIDTH-1:0] w_product;
    logic [WIDTH-1:0] w_alu_res;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [SHAMT_W-1:0] w_shamt;

    assign bus.in_ready = (r_state == IDLE) || (r_state == DONE && bus.out_ready && !w_mul_busy);
    assign w_accept     = bus.in_valid && bus.in_ready;
    assign w_start_mul  = w_accept && (bus.ALU_Op == ALU_MUL);
    assign w_shamt      = bus.B[SHAMT_W-1:0];

`ifdef ALU_FLAGS_EN
    logic [WIDTH:0] w_sum_x;
    logic [WIDTH:0] w_diff_x;
    logic [3:0]     w_alu_flags;
    logic [3:0]     w_mul_flags;
    logic [3:0]     r_flags;

    assign w_sum_x  = {1'b0, bus.A} + {1'b0, bus.B};
    assign w_diff_x = {1'b0, bus.A} - {1'b0, bus.B};
    assign w_sum    = w_sum_x[WIDTH-1:0];
    assign w_diff   = w_diff_x[WIDTH-1:0];

    always_comb begin
        w_alu_flags         = '0;
        w_alu_flags[FLAG_N] = w_alu_res[WIDTH-1];
        w_alu_flags[FLAG_Z] = (w_alu_res == '0);
        if (bus.ALU_Op == ALU_ADD) begin
            w_alu_flags[FLAG_C] = w_sum_x[WIDTH];
            w_alu_flags[FLAG_V] = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) &&
                                  (w_sum[WIDTH-1] != bus.A[WIDTH-1]);
        end else if (bus.ALU_Op == ALU_SUB) begin
            // C is the inverted borrow out of the subtraction.
            w_alu_flags[FLAG_C] = ~w_diff_x[WIDTH];
            w_alu_flags[FLAG_V] = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) &&
                                  (w_diff[WIDTH-1] != bus.A[WIDTH-1]);
        end
    end

    assign w_mul_flags = {w_product[WIDTH-1], (w_product == '0), 2'b00};
    assign bus.Flags   = r_flags;
`else
    assign w_sum  = bus.A + bus.B;
    assign w_diff = bus.A - bus.B;
`endif

    always_comb begin
        w_alu_res = '0;
        case (bus.ALU_Op)
            ALU_ADD:  w_alu_res = w_sum;
            ALU_SUB:  w_alu_res = w_diff;
            ALU_AND:  w_alu_res = bus.A & bus.B;
            ALU_OR:   w_alu_res = bus.A | bus.B;
            ALU_SLL:  w_alu_res = bus.A << w_shamt;
            ALU_SRL:  w_alu_res = bus.A >> w_shamt;
            ALU_SRA:  w_alu_res = $unsigned($signed(bus.A) >>> w_shamt);
            ALU_XOR:  w_alu_res = bus.A ^ bus.B;
            ALU_SLT:  w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
            ALU_SLTU: w_alu_res = {{(WIDTH-1){1'b0}}, (bus.A < bus.B)};
            default:  w_alu_res = '0;
        endcase
    end

    seq_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk          (clk),
        .rst          (rst),
        .i_start      (w_start_mul),
        .i_a          (bus.A),
        .i_b          (bus.B),
        .o_busy       (w_mul_busy),
        .o_done       (w_mul_done),
        .o_product_lo (w_product)
    );

    // DONE with in_ready high behaves exactly like IDLE, giving 1 beat/cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_result    <= '0;
            r_out_valid <= 1'b0;
`ifdef ALU_FLAGS_EN
            r_flags     <= '0;
`endif
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (w_accept) begin
                        if (bus.ALU_Op == ALU_MUL) begin
                            r_state     <= BUSY;
                            r_out_valid <= 1'b0;
                        end else begin
                            r_state     <= DONE;
                            r_result    <= w_alu_res;
                            r_out_valid <= 1'b1;
`ifdef ALU_FLAGS_EN
                            r_flags     <= w_alu_flags;
`endif
                        end
                    end else if (r_state == IDLE || bus.out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
                BUSY: begin
                    if (w_mul_done) begin
                        r_state     <= DONE;
                        r_result    <= w_product;
                        r_out_valid <= 1'b1;
`ifdef ALU_FLAGS_EN
                        r_flags     <= w_mul_flags;
`endif
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.Result    = r_result;
    assign o_state       = r_state;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu (WIDTH=32); flag checks are included when ALU_FLAGS_EN is defined.
module tb_seq_alu;
    import alu_pkg::*;

    logic   clk;
    logic   rst;
    state_t dbg_state;
    int     n_checks;
    int     n_errors;
    logic [31:0] exp_q[$];

    seq_alu_if #(.WIDTH(32)) bus ();

    seq_alu #(.WIDTH(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .o_state (dbg_state)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected $finish before 200000");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Scoreboard: every delivered beat must match the oldest expected result.
    always @(posedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            check("sb_pending", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                check("sb_result", bus.Result, exp_q.pop_front());
            end
        end
    end

    // Driver: starts at a negedge, returns at the negedge after the accept edge.
    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, output int waits);
        bus.in_valid = 1'b1;
        bus.ALU_Op   = op;
        bus.A        = a;
        bus.B        = b;
        exp_q.push_back(exp);
        #1;
        waits = 0;
        while (!bus.in_ready && waits < 200) begin
            @(negedge clk);
            #1;
            waits++;
        end
        check("accepted", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.A        = $urandom();
        bus.B        = $urandom();
    endtask

    // Counts negedges until out_valid, also counting cycles where in_ready was high.
    task automatic wait_result(output int lat, output int ready_seen);
        lat        = 0;
        ready_seen = 0;
        while (!bus.out_valid && lat < 100) begin
            if (bus.in_ready) ready_seen++;
            @(negedge clk);
            lat++;
        end
    endtask

    logic [3:0]  t_op [8];
    logic [31:0] t_a  [8];
    logic [31:0] t_b  [8];
    logic [31:0] t_r  [8];

    initial begin
        int w;
        int lat;
        int rdy;
        n_checks = 0;
        n_errors = 0;

        t_op = '{ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLL, ALU_XOR, ALU_SLT, ALU_SLTU, 4'b1111};
        t_a  = '{32'd1, 32'd16, 32'h8000_0000, 32'd1, 32'h0000_00F0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1234_5678};
        t_b  = '{32'd4, 32'd2,  32'd4,         32'd36, 32'h0000_00FF, 32'd1,       32'd1,         32'h0000_0001};
        t_r  = '{32'd16, 32'd4, 32'hF800_0000, 32'd16, 32'h0000_000F, 32'd1,       32'd0,         32'd0};

        // Reset
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.A         = '0;
        bus.B         = '0;
        bus.ALU_Op    = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_result", bus.Result, 32'd0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
`ifdef ALU_FLAGS_EN
        check("rst_flags", 32'(bus.Flags), 32'd0);
`endif
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);

        // Basic arithmetic, one cycle latency
        send(ALU_ADD, 32'd10, 32'd5, 32'd15, w);
        check("add_valid", 32'(bus.out_valid), 32'd1);
        check("add_result", bus.Result, 32'd15);
`ifdef ALU_FLAGS_EN
        check("add_flags", 32'(bus.Flags), 32'b0000);
`endif
        send(ALU_SUB, 32'd20, 32'd7, 32'd13, w);
        check("sub_result", bus.Result, 32'd13);
`ifdef ALU_FLAGS_EN
        check("sub_flags", 32'(bus.Flags), 32'b0010);
`endif
        send(ALU_SUB, 32'd0, 32'd1, 32'hFFFF_FFFF, w);
        check("sub_wrap_result", bus.Result, 32'hFFFF_FFFF);
`ifdef ALU_FLAGS_EN
        check("sub_wrap_flags", 32'(bus.Flags), 32'b1000);
`endif

        // Shifts, XOR, compares and undefined op, back-to-back
        for (int i = 0; i < 8; i++) begin
            send(t_op[i], t_a[i], t_b[i], t_r[i], w);
            check($sformatf("tbl%0d_no_bubble", i), 32'(w), 32'd0);
            check($sformatf("tbl%0d_valid", i), 32'(bus.out_valid), 32'd1);
            check($sformatf("tbl%0d_result", i), bus.Result, t_r[i]);
        end
`ifdef ALU_FLAGS_EN
        check("undef_flags", 32'(bus.Flags), 32'b0100);
`endif
        @(negedge clk);

        // Multiplier latency and wrap
        send(ALU_MUL, 32'd6, 32'd7, 32'd42, w);
        wait_result(lat, rdy);
        check("mul_latency", 32'(lat), 32'd33);
        check("mul_in_ready_low", 32'(rdy), 32'd0);
        check("mul_result", bus.Result, 32'd42);
        @(negedge clk);
        send(ALU_MUL, 32'h0001_0000, 32'h0001_0000, 32'd0, w);
        wait_result(lat, rdy);
        check("mul_wrap_latency", 32'(lat), 32'd33);
        check("mul_wrap_result", bus.Result, 32'd0);
`ifdef ALU_FLAGS_EN
        check("mul_wrap_flags", 32'(bus.Flags), 32'b0100);
`endif
        @(negedge clk);

        // Backpressure holds the result, release accepts next beat with no bubble
        bus.out_ready = 1'b0;
        send(ALU_AND, 32'hC, 32'hA, 32'h8, w);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 32'(bus.out_valid), 32'd1);
            check("bp_result", bus.Result, 32'h8);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        send(ALU_OR, 32'hC, 32'hA, 32'hE, w);
        check("bp_release_no_bubble", 32'(w), 32'd0);
        check("bp_or_result", bus.Result, 32'hE);
        @(negedge clk);

        // Reset in the middle of a multiply discards it
        send(ALU_MUL, 32'd6, 32'd7, 32'd42, w);
        repeat (9) @(negedge clk);
        check("mid_mul_state", 32'(dbg_state), 32'(BUSY));
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        check("abort_out_valid", 32'(bus.out_valid), 32'd0);
        check("abort_result", bus.Result, 32'd0);
        check("abort_in_ready", 32'(bus.in_ready), 32'd1);
        check("abort_state", 32'(dbg_state), 32'(IDLE));
        send(ALU_ADD, 32'd2, 32'd3, 32'd5, w);
        check("post_abort_valid", 32'(bus.out_valid), 32'd1);
        check("post_abort_result", bus.Result, 32'd5);
        @(negedge clk);
        send(ALU_MUL, 32'd3, 32'd4, 32'd12, w);
        wait_result(lat, rdy);
        check("post_abort_mul_latency", 32'(lat), 32'd33);
        check("post_abort_mul_result", bus.Result, 32'd12);

        repeat (3) @(negedge clk);
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        check("final_idle", 32'(dbg_state), 32'(IDLE));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
